// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and the write-request record used by the write-back port arbiter and its FIFO.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

  typedef enum logic [1:0] {
    GrantNone,
    GrantPipe,
    GrantBuf
  } grant_e;

  // Register 0 is hard-wired, so a write to it is dropped at the port.
  function automatic logic is_live(wr_req_t req);
    return req.en && (req.addr != '0);
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO buffering multi-cycle unit results until the write port is free.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wr_req_t          wdata,
  input  logic             pop,
  output wr_req_t          rdata,
  output logic [CNT_W-1:0] count
);

  wr_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Guards keep the pointers coherent even if a caller misbehaves.
  assign push_ok = push && (count_q < CNT_W'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the MEM/WB pipeline and buffered
// multi-cycle results, stalling the pipeline when the buffer is full or starved too long.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DEPTH        = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  WBRegWriteIn,
  input  logic [REG_ADDR_W-1:0] WBDstAddrIn,
  input  logic [DATA_W-1:0]     WBDataIn,
  input  logic                  MDValidIn,
  input  logic [REG_ADDR_W-1:0] MDDstAddrIn,
  input  logic [DATA_W-1:0]     MDDataIn,
  output logic                  MDReadyOut,
  output logic                  StallOut,
  output logic                  RegWriteOut,
  output logic [REG_ADDR_W-1:0] WriteAddrOut,
  output logic [DATA_W-1:0]     WriteDataOut
);

  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CNT_W-1:0]    count;
  wr_req_t             buf_head;
  wr_req_t             md_req;
  wr_req_t             sel_req;
  logic                buf_nonempty, buf_full, starved;
  logic                md_push, buf_pop;
  grant_e              grant;
  logic [STARVE_W-1:0] starve_q, starve_d;
  wr_req_t             wr_q, wr_d;

  assign buf_nonempty = (count != '0);
  assign buf_full     = (count >= CNT_W'(DEPTH));
  assign starved      = (starve_q >= STARVE_W'(STARVE_LIMIT));
  assign MDReadyOut   = !buf_full;
  assign md_push      = MDValidIn && MDReadyOut;
  assign buf_pop      = (grant == GrantBuf);
  assign md_req       = '{en: 1'b1, addr: MDDstAddrIn, data: MDDataIn};

  wb_result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (Clk),
    .rst  (Rst),
    .push (md_push),
    .wdata(md_req),
    .pop  (buf_pop),
    .rdata(buf_head),
    .count(count)
  );

  // The pipeline wins unless the buffer is full or its head has waited too long.
  always_comb begin
    grant    = GrantNone;
    StallOut = 1'b0;
    if (!WBRegWriteIn) begin
      if (buf_nonempty) grant = GrantBuf;
    end else if (!buf_nonempty) begin
      grant = GrantPipe;
    end else if (buf_full || starved) begin
      grant    = GrantBuf;
      StallOut = 1'b1;
    end else begin
      grant = GrantPipe;
    end
  end

  always_comb begin
    sel_req = '0;
    unique case (grant)
      GrantPipe: sel_req = '{en: 1'b1, addr: WBDstAddrIn, data: WBDataIn};
      GrantBuf:  sel_req = buf_head;
      default:   sel_req = '0;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!buf_nonempty || (grant == GrantBuf)) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Idle cycles keep the last address/data and only drop the enable.
  always_comb begin
    wr_d    = wr_q;
    wr_d.en = 1'b0;
    if (sel_req.en) begin
      wr_d.en   = is_live(sel_req);
      wr_d.addr = sel_req.addr;
      wr_d.data = sel_req.data;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      starve_q <= '0;
      wr_q     <= '0;
    end else begin
      starve_q <= starve_d;
      wr_q     <= wr_d;
    end
  end

  assign RegWriteOut  = wr_q.en;
  assign WriteAddrOut = wr_q.addr;
  assign WriteDataOut = wr_q.data;

endmodule
